// File: rtl/maroc_dc_regbank.sv
// AXI4-Lite register bank: NUM_CTRL RW control words followed by NUM_STAT RO status words.
// Byte strobes, self-clearing pulse bits, per-register write strobes, SLVERR on illegal access.
module maroc_dc_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_RESET = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] PULSE_MASK = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0]                  ctrl_wr_stb,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*C_S_AXI_DATA_WIDTH-1:0] stat_in
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int BW  = DW / 8;
  localparam int LSB = $clog2(BW);
  localparam int IW  = AW - LSB;
  localparam logic [DW-1:0] KEEP = ~PULSE_MASK;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IW-1:0] awidx_q, awidx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [DW-1:0] ctrl_q [NUM_CTRL];
  logic [DW-1:0] ctrl_d [NUM_CTRL];
  logic [NUM_CTRL-1:0] stb_q, stb_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] widx;
  logic [31:0]   widx32, ridx32;
  logic [DW-1:0] wdat;
  logic [BW-1:0] wstb;
  logic          unused_ok;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q && !ARESET;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q && !ARESET;
  assign S_AXI_ARREADY = !rvalid_q && !ARESET;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign ctrl_wr_stb   = stb_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Commit as soon as both halves are available, whether latched earlier or arriving now.
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign widx   = aw_held_q ? awidx_q : S_AXI_AWADDR[AW-1:LSB];
  assign wdat   = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wstb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign widx32 = 32'(widx);
  assign ridx32 = 32'(S_AXI_ARADDR[AW-1:LSB]);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                       S_AXI_ARADDR[LSB-1:0], stat_in};

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_out
    assign ctrl_out[k*DW +: DW] = ctrl_q[k];
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    stb_d     = '0;
    // Pulse bits live for one cycle only.
    for (int k = 0; k < NUM_CTRL; k++) ctrl_d[k] = ctrl_q[k] & KEEP;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = S_AXI_AWADDR[AW-1:LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (widx32 < NUM_CTRL) ? 2'b00 : 2'b10;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (widx32 == 32'(k)) begin
          stb_d[k] = 1'b1;
          for (int b = 0; b < BW; b++)
            if (wstb[b]) ctrl_d[k][b*8 +: 8] = wdat[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = 2'b10;
      rdata_d  = '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (ridx32 == 32'(k)) begin
          rdata_d = ctrl_q[k] & KEEP;
          rresp_d = 2'b00;
        end
      end
      for (int s = 0; s < NUM_STAT; s++) begin
        if (ridx32 == 32'(NUM_CTRL + s)) begin
          rdata_d = stat_in[s*DW +: DW];
          rresp_d = 2'b00;
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      stb_q     <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET & KEEP;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      stb_q     <= stb_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= ctrl_d[k];
    end
  end

endmodule

// File: tb/tb_maroc_dc_regbank.sv
// Directed bench for maroc_dc_regbank: a default instance and a pulse-bit instance
// share the same AXI stimulus; expected values are hand-computed.
module tb_maroc_dc_regbank;
  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [127:0] stat_in;

  logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]   a_bresp, a_rresp;
  logic [31:0]  a_rdata;
  logic [255:0] a_ctrl;
  logic [7:0]   a_stb;
  logic         p_awready, p_wready, p_bvalid, p_arready, p_rvalid;
  logic [1:0]   p_bresp, p_rresp;
  logic [31:0]  p_rdata;
  logic [255:0] p_ctrl;
  logic [7:0]   p_stb;

  int n_chk = 0;
  int n_fail = 0;
  int stb_cnt [8];
  logic [31:0] exp_a [8];

  always #5 ACLK = ~ACLK;

  maroc_dc_regbank u_dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(a_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(a_wready),
    .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(a_arready),
    .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(rready),
    .ctrl_out(a_ctrl), .ctrl_wr_stb(a_stb), .stat_in(stat_in)
  );

  maroc_dc_regbank #(.CTRL_RESET(32'h5A5A_00F1), .PULSE_MASK(32'h0000_0001)) u_pls (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(p_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(p_wready),
    .S_AXI_BRESP(p_bresp), .S_AXI_BVALID(p_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(p_arready),
    .S_AXI_RDATA(p_rdata), .S_AXI_RRESP(p_rresp), .S_AXI_RVALID(p_rvalid), .S_AXI_RREADY(rready),
    .ctrl_out(p_ctrl), .ctrl_wr_stb(p_stb), .stat_in(stat_in)
  );

  always @(negedge ACLK)
    for (int k = 0; k < 8; k++) if (a_stb[k]) stb_cnt[k] = stb_cnt[k] + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(a_ctrl[k*32 +: 32]), 64'(exp_a[k]));
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [7:0] stb);
    logic aw_go, w_go;
    int t;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    while ((awvalid || wvalid) && t < 20) begin
      aw_go = awvalid && a_awready;
      w_go  = wvalid && a_wready;
      @(negedge ACLK);
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      t++;
    end
    while (!a_bvalid && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    chk("wr_done", 64'(a_bvalid), 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    resp = a_bresp;
    stb = a_stb;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] da, output logic [1:0] ra,
                          output logic [31:0] dp);
    logic go;
    int t;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (arvalid && t < 20) begin
      go = a_arready;
      @(negedge ACLK);
      if (go) arvalid = 1'b0;
      t++;
    end
    while (!a_rvalid && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    chk("rd_done", 64'(a_rvalid), 64'd1);
    arvalid = 1'b0;
    da = a_rdata; ra = a_rresp; dp = p_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [7:0]  s;
    logic [31:0] da, dp;
    int base [8];

    for (int k = 0; k < 8; k++) begin
      stb_cnt[k] = 0;
      exp_a[k] = 32'h0;
    end
    ARESET = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    stat_in = {32'h0BAD_F00D, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};

    #3;
    chk("rst_awready", 64'(a_awready), 64'd0);
    chk("rst_wready", 64'(a_wready), 64'd0);
    chk("rst_arready", 64'(a_arready), 64'd0);
    chk("rst_bvalid", 64'(a_bvalid), 64'd0);
    chk("rst_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_rdata", 64'(a_rdata), 64'd0);
    chk("rst_resp", 64'({a_bresp, a_rresp}), 64'd0);
    chk("rst_stb", 64'(a_stb), 64'd0);
    chk_ctrl("rst_ctrl");
    chk("rst_pls_w0", 64'(p_ctrl[31:0]), 64'h5A5A_00F0);
    chk("rst_pls_w7", 64'(p_ctrl[255:224]), 64'h5A5A_00F0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("post_rst_awready", 64'(a_awready), 64'd1);

    // Basic writes and read-back
    for (int k = 0; k < 8; k++) base[k] = stb_cnt[k];
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(i * 4), 32'(i + 1), 4'hF, r, s);
      chk($sformatf("t1_bresp%0d", i), 64'(r), 64'd0);
      chk($sformatf("t1_stb%0d", i), 64'(s), 64'(8'd1 << i));
      exp_a[i] = 32'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i * 4), da, r, dp);
      chk($sformatf("t1_rdata%0d", i), 64'(da), 64'(i + 1));
      chk($sformatf("t1_rresp%0d", i), 64'(r), 64'd0);
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("t1_stbcnt%0d", k), 64'(stb_cnt[k] - base[k]), (k < 4) ? 64'd1 : 64'd0);
    chk_ctrl("t1_ctrl");

    // Byte strobes
    axi_write(8'h00, 32'hAABB_CCDD, 4'hF, r, s);
    axi_write(8'h00, 32'h1122_3344, 4'b0101, r, s);
    chk("t2_bresp", 64'(r), 64'd0);
    exp_a[0] = 32'hAA22_CC44;
    chk("t2_ctrl0", 64'(a_ctrl[31:0]), 64'hAA22_CC44);
    axi_read(8'h00, da, r, dp);
    chk("t2_rdata", 64'(da), 64'hAA22_CC44);

    // W three cycles ahead of AW, BREADY held off for five cycles
    @(negedge ACLK);
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    chk("t3_wready0", 64'(a_wready), 64'd1);
    @(negedge ACLK);
    wvalid = 1'b0;
    chk("t3_wready_held", 64'(a_wready), 64'd0);
    chk("t3_awready_open", 64'(a_awready), 64'd1);
    chk("t3_no_stb", 64'(a_stb), 64'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    awaddr = 8'h10; awvalid = 1'b1;
    chk("t3_pre_commit", 64'(a_ctrl[159:128]), 64'd0);
    chk("t3_pre_bvalid", 64'(a_bvalid), 64'd0);
    @(negedge ACLK);
    awvalid = 1'b0;
    exp_a[4] = 32'h55;
    chk("t3_commit", 64'(a_ctrl[159:128]), 64'h55);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_bvalid%0d", i), 64'(a_bvalid), 64'd1);
      chk($sformatf("t3_bresp%0d", i), 64'(a_bresp), 64'd0);
      chk($sformatf("t3_readies%0d", i), 64'({a_awready, a_wready}), 64'd0);
      chk($sformatf("t3_stb%0d", i), 64'(a_stb), (i == 0) ? 64'h10 : 64'h0);
      if (i == 4) bready = 1'b1;
      @(negedge ACLK);
    end
    chk("t3_bvalid_clr", 64'(a_bvalid), 64'd0);
    chk("t3_awready_back", 64'(a_awready), 64'd1);

    // Status, unmapped and zero-strobe accesses
    axi_read(8'h20, da, r, dp);
    chk("t4_stat0", 64'(da), 64'hDEAD_BEEF);
    chk("t4_stat0_resp", 64'(r), 64'd0);
    axi_read(8'h2C, da, r, dp);
    chk("t4_stat3", 64'(da), 64'h0BAD_F00D);
    axi_write(8'h20, 32'hFFFF_FFFF, 4'hF, r, s);
    chk("t4_wr_ro_resp", 64'(r), 64'd2);
    chk("t4_wr_ro_stb", 64'(s), 64'd0);
    axi_write(8'h30, 32'hFFFF_FFFF, 4'hF, r, s);
    chk("t4_wr_unmap_resp", 64'(r), 64'd2);
    chk("t4_wr_unmap_stb", 64'(s), 64'd0);
    axi_read(8'h30, da, r, dp);
    chk("t4_rd_unmap_data", 64'(da), 64'd0);
    chk("t4_rd_unmap_resp", 64'(r), 64'd2);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'h0, r, s);
    chk("t4_strb0_resp", 64'(r), 64'd0);
    chk("t4_strb0_stb", 64'(s), 64'h02);
    axi_read(8'h0B, da, r, dp);
    chk("t4_lowbits", 64'(da), 64'd3);
    chk_ctrl("t4_ctrl");

    // Self-clearing pulse bit
    chk("t5_pre_bit0", 64'(p_ctrl[0]), 64'd0);
    axi_write(8'h00, 32'h0000_0003, 4'hF, r, s);
    exp_a[0] = 32'h3;
    chk("t5_pulse_hi", 64'(p_ctrl[31:0]), 64'h3);
    @(negedge ACLK);
    chk("t5_pulse_lo", 64'(p_ctrl[31:0]), 64'h2);
    @(negedge ACLK);
    chk("t5_pulse_stay", 64'(p_ctrl[31:0]), 64'h2);
    axi_read(8'h00, da, r, dp);
    chk("t5_rd_pls", 64'(dp), 64'h2);
    chk("t5_rd_dflt", 64'(da), 64'h3);

    // Reset with both responses outstanding; read and write same register on one edge
    @(negedge ACLK);
    awaddr = 8'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 8'h08; arvalid = 1'b1; rready = 1'b0;
    chk("t6_ready", 64'({a_awready, a_wready, a_arready}), 64'h7);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t6_bvalid", 64'(a_bvalid), 64'd1);
    chk("t6_rvalid", 64'(a_rvalid), 64'd1);
    chk("t6_rd_prewrite", 64'(a_rdata), 64'd3);
    chk("t6_new_w2", 64'(a_ctrl[95:64]), 64'h77);
    #2;
    ARESET = 1'b1;
    #1;
    chk("t6_rst_valids", 64'({a_bvalid, a_rvalid}), 64'd0);
    chk("t6_rst_readies", 64'({a_awready, a_wready, a_arready}), 64'd0);
    chk("t6_rst_resp", 64'({a_bresp, a_rresp}), 64'd0);
    chk("t6_rst_rdata", 64'(a_rdata), 64'd0);
    chk("t6_rst_stb", 64'(a_stb), 64'd0);
    for (int k = 0; k < 8; k++) exp_a[k] = 32'h0;
    chk_ctrl("t6_rst_ctrl");
    chk("t6_rst_pls", 64'(p_ctrl[31:0]), 64'h5A5A_00F0);
    @(negedge ACLK);
    ARESET = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    chk("t6_no_stale_resp", 64'({a_bvalid, a_rvalid}), 64'd0);
    axi_write(8'h04, 32'h9, 4'hF, r, s);
    chk("t6_wr_resp", 64'(r), 64'd0);
    exp_a[1] = 32'h9;
    axi_read(8'h04, da, r, dp);
    chk("t6_rd", 64'(da), 64'h9);
    chk("t6_rd_resp", 64'(r), 64'd0);
    chk("t6_ctrl0", 64'(a_ctrl[31:0]), 64'd0);
    chk("t6_pls0", 64'(p_ctrl[31:0]), 64'h5A5A_00F0);
    chk_ctrl("t6_ctrl");

    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maroc_dc_regbank.md
Name: maroc_dc_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed four-register maroc_dc slave.
- Provides NUM_CTRL read/write control registers and NUM_STAT read-only status registers.
- Adds byte strobes, self-clearing pulse bits, per-register write strobes, and SLVERR on illegal accesses.
- Sits between the PS AXI interconnect and the MAROC data-collection logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width in bits; must be 32 or 64.
C_S_AXI_ADDR_WIDTH, 8, byte address width.
NUM_CTRL, 8, number of RW control registers; must be 1 or more.
NUM_STAT, 4, number of RO status registers; must be 0 or more.
CTRL_RESET, 0, reset value applied to every control register.
PULSE_MASK, 0, DW-bit mask; set bits in every control register self-clear.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DW  write data
S_AXI_WSTRB  in  DW/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
ctrl_out  out  NUM_CTRL*DW  control registers; register k occupies [k*DW +: DW]
ctrl_wr_stb  out  NUM_CTRL  one-cycle pulse on bit k when register k is written
stat_in  in  NUM_STAT*DW  status inputs, already synchronous to ACLK

Behaviour:
- Word index = addr[ADDR_WIDTH-1 : log2(DW/8)]; low address bits are ignored.
- Index 0 to NUM_CTRL-1: control registers (RW).
- Index NUM_CTRL to NUM_CTRL+NUM_STAT-1: status registers (RO).
- Higher indices: unmapped.
- Reset (asynchronous, active-high):
  - All READY/VALID outputs 0; BRESP, RRESP, RDATA 0; ctrl_wr_stb 0.
  - ctrl_out = CTRL_RESET with PULSE_MASK bits forced to 0.
  - An in-flight transaction is discarded; no response is issued after reset.
- Write channel:
  - AW and W are accepted independently, in either order, into aw_held/w_held latches.
  - AWREADY = !aw_held && !BVALID && !ARESET; WREADY = !w_held && !BVALID && !ARESET.
  - Commit edge: the edge where both are held, or where both handshakes complete together. At that edge:
    - Target register updates byte-wise per WSTRB.
    - BVALID rises; the held flags clear.
    - ctrl_wr_stb[k] is high for the following cycle only.
  - BVALID holds, and BRESP stays stable, until BREADY is sampled high. One outstanding write.
  - Write to a RO or unmapped index: no state change, no strobe, BRESP=10.
  - WSTRB=0 to a RW index: no data change, strobe still pulses, BRESP=00.
- Pulse bits:
  - PULSE_MASK bits are high in ctrl_out for exactly one cycle after a commit that writes them with 1, then clear.
  - Pulse bits always read back 0.
- Read channel:
  - ARREADY = !RVALID && !ARESET.
  - On the AR handshake edge, RDATA is registered from the control register (pulse bits masked) or from stat_in, and RVALID rises.
  - Unmapped index: RDATA=0, RRESP=10; otherwise RRESP=00.
  - RVALID holds, with RDATA/RRESP stable, until RREADY is high. One outstanding read.
- Concurrency:
  - Read and write channels are fully concurrent.
  - A read handshake on the same edge as a write commit to the same register returns the pre-write value.
- Minimum rate: with READY/VALID always high, one write per 2 cycles and one read per 2 cycles.

Test Plan:
1. Defaults, DW=32, NUM_CTRL=8: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> data matches, BRESP=RRESP=00, ctrl_wr_stb bits 0 to 3 each pulse exactly once.
2. Write 0xAABBCCDD to 0x0, then write 0x11223344 with WSTRB=4'b0101 -> ctrl_out[31:0]=0xAA22CC44; read returns 0xAA22CC44.
3. W presented 3 cycles before AW, BREADY held low 5 cycles -> commit on the AW handshake edge; BVALID stays high and stable for 5 cycles; AWREADY/WREADY stay low while BVALID is high.
4. stat_in[31:0]=0xDEADBEEF: read 0x20 -> 0xDEADBEEF/OKAY; write 0x20 -> BRESP=10, no strobe; read 0x30 -> RDATA=0, RRESP=10.
5. PULSE_MASK=0x1: write 0x3 to 0x0 -> ctrl_out[0] high exactly 1 cycle, ctrl_out[1] stays high; read 0x0 returns 0x2.
6. Assert ARESET while BVALID=1 and RVALID=1 -> all outputs 0 asynchronously; after release the next write/read completes normally and ctrl_out[31:0]=CTRL_RESET.
